// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : Five-state stopwatch/timer controller. It owns a DIGITS-digit
//                BCD up/down counter, a tick prescaler, a lap (display freeze)
//                register, preset load and done/overflow indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_stop,
    input  logic                  lap_rst,
    input  logic                  dir,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   preset,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic [2:0]            state,
    output logic                  count_en,
    output logic                  done,
    output logic                  ovf
);

    localparam int c_W  = 4 * DIGITS;
    localparam int c_PW = $clog2(TICK_DIV);
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [c_W-1:0]  c_ALL_NINE  = {DIGITS{4'h9}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_PAUSE = 3'd2,
        S_LAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [c_W-1:0]  r_count;
    logic [c_W-1:0]  r_lap;
    logic [c_PW-1:0] r_presc;
    logic            r_dir;
    logic            r_ovf;
    logic            w_tick;
    logic            w_zero_reached;
    logic            w_step;

    // BCD increment with digit-serial carry; all-9s wraps to all-0s.
    function automatic logic [c_W-1:0] bcd_inc(input logic [c_W-1:0] v);
        logic [c_W-1:0] res;
        logic           carry;
        logic [3:0]     nib;
        res   = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = v[4*i +: 4];
            if (carry) begin
                if (nib == 4'd9) begin
                    nib = 4'd0;
                end else begin
                    nib   = nib + 4'd1;
                    carry = 1'b0;
                end
            end
            res[4*i +: 4] = nib;
        end
        return res;
    endfunction

    // BCD decrement with digit-serial borrow; callers never pass zero.
    function automatic logic [c_W-1:0] bcd_dec(input logic [c_W-1:0] v);
        logic [c_W-1:0] res;
        logic           borrow;
        logic [3:0]     nib;
        res    = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = v[4*i +: 4];
            if (borrow) begin
                if (nib == 4'd0) begin
                    nib = 4'd9;
                end else begin
                    nib    = nib - 4'd1;
                    borrow = 1'b0;
                end
            end
            res[4*i +: 4] = nib;
        end
        return res;
    endfunction

    // Clamp every non-decimal nibble of a preset to 9.
    function automatic logic [c_W-1:0] bcd_clamp(input logic [c_W-1:0] v);
        logic [c_W-1:0] res;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return res;
    endfunction

    assign count_en       = (r_state == S_COUNT) || (r_state == S_LAP);
    assign done           = (r_state == S_DONE);
    assign state          = r_state;
    assign count_bcd      = r_count;
    assign disp_bcd       = (r_state == S_LAP) ? r_lap : r_count;
    assign ovf            = r_ovf;
    assign w_tick         = count_en && (r_presc == c_PRESC_MAX);
    // Once a down count has hit zero the counter must not step again.
    assign w_zero_reached = r_dir && (r_count == '0);
    assign w_step         = w_tick && !w_zero_reached;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start_stop outranks lap_rst, zero-reached outranks both.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_stop && !(dir && (r_count == '0))) begin
                    w_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (w_zero_reached)  w_next = S_DONE;
                else if (start_stop) w_next = S_PAUSE;
                else if (lap_rst)    w_next = S_LAP;
            end
            S_LAP: begin
                if (w_zero_reached)  w_next = S_DONE;
                else if (start_stop) w_next = S_PAUSE;
                else if (lap_rst)    w_next = S_COUNT;
            end
            S_PAUSE: begin
                if (start_stop)      w_next = S_COUNT;
                else if (lap_rst)    w_next = S_IDLE;
            end
            S_DONE: begin
                if (start_stop || lap_rst) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Prescaler: runs while counting, holds in PAUSE, clears when entering IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_next == S_IDLE) begin
            r_presc <= '0;
        end else if (count_en) begin
            r_presc <= (r_presc == c_PRESC_MAX) ? '0 : r_presc + c_PW'(1);
        end
    end

    // Counter, direction latch, lap capture and overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_lap   <= '0;
            r_dir   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (r_state == S_IDLE) begin
                if (load) begin
                    r_count <= bcd_clamp(preset);
                end
                if (w_next == S_COUNT) begin
                    r_dir <= dir;
                end
            end else if ((r_state == S_PAUSE) && (w_next == S_IDLE)) begin
                r_count <= '0;
            end else if (w_step) begin
                if (r_dir) begin
                    r_count <= bcd_dec(r_count);
                end else begin
                    r_count <= bcd_inc(r_count);
                    r_ovf   <= (r_count == c_ALL_NINE);
                end
            end
            // Non-blocking capture keeps the pre-tick value if a step coincides.
            if ((r_state == S_COUNT) && (w_next == S_LAP)) begin
                r_lap <= r_count;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Parametrised stopwatch/timer controller. It replaces the single-bit count/pause toggle with a five-state controller that owns a DIGITS-digit BCD counter and a tick prescaler. It supports up or down counting, a lap (display freeze) mode, preset load and a done indication. It sits between the debounced one-pulse button blocks and the seven-segment display scanner.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits (≥1); counter width is 4*DIGITS.
- TICK_DIV, 1000000, clk cycles per count step (≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start_stop  in  1  single-cycle pulse: start/pause toggle.
- lap_rst  in  1  single-cycle pulse: lap / clear.
- dir  in  1  0 = count up, 1 = count down; sampled only in IDLE.
- load  in  1  single-cycle pulse: load preset; honoured only in IDLE.
- preset  in  4*DIGITS  BCD preset value.
- count_bcd  out  4*DIGITS  live counter value.
- disp_bcd  out  4*DIGITS  value for display (frozen in LAP).
- state  out  3  current state encoding.
- count_en  out  1  high while the counter is running.
- done  out  1  high while in DONE.
- ovf  out  1  one-cycle pulse on up-count wrap.

## Operation
States and encoding: IDLE=0, COUNT=1, PAUSE=2, LAP=3, DONE=4. Encodings 5–7 are illegal and go to IDLE on the next clk.

Transitions (evaluated on each clk edge; start_stop has priority over lap_rst when both pulse in the same cycle):
- IDLE:
  - start_stop → COUNT and latch dir into dir_q.
  - If dir=1 and count_bcd=0, start_stop is ignored and the block stays in IDLE.
  - load → count_bcd <= preset. Any nibble >9 is clamped to 9.
- COUNT:
  - start_stop → PAUSE.
  - lap_rst → LAP and capture count_bcd into lap_reg.
  - Down tick that produces 0 → DONE.
- LAP:
  - start_stop → PAUSE.
  - lap_rst → COUNT.
  - Down tick that produces 0 → DONE.
  - Counting continues in this state.
- PAUSE:
  - start_stop → COUNT.
  - lap_rst → IDLE, with count_bcd <= 0 and the prescaler cleared.
- DONE:
  - start_stop or lap_rst → IDLE. count_bcd stays at 0.

Decoded outputs:
- count_en = (state==COUNT) || (state==LAP). This is a Moore decode of the registered state.
- done = (state==DONE).
- disp_bcd = lap_reg in LAP, otherwise count_bcd.

Prescaler:
- Range is 0..TICK_DIV-1, width $clog2(TICK_DIV).
- Advances only while count_en=1 and holds its value in PAUSE.
- When it reaches TICK_DIV-1 with count_en=1, it wraps to 0 and asserts an internal tick for one cycle.
- It is cleared to 0 on entry to IDLE.

Counter arithmetic (BCD, digit-serial carry/borrow within one cycle):
- Up: digit 9 → 0 with carry. All-9s → all-0s with ovf=1 for that cycle. The counter keeps running.
- Down: digit 0 → 9 with borrow. Reaching 0 forces DONE, so the counter never wraps below 0.
- load, dir and preset have no effect outside IDLE.

Reset (asynchronous) values:
- state=IDLE, count_bcd=0, lap_reg=0, prescaler=0, dir_q=0.
- Outputs: disp_bcd=0, count_en=0, done=0, ovf=0.
- Reset asserted mid-count aborts immediately. No tick or ovf is emitted afterwards.

## Timing
- A pulse sampled at edge t changes state, count_en and done at t+1.
- The first tick occurs TICK_DIV cycles after count_en rises. count_bcd updates on the edge after the tick.
- Resume from PAUSE continues the prescaler from its held value, so no partial period is lost.
- On LAP entry, lap_reg holds count_bcd as it was on the cycle lap_rst was sampled. If a tick coincides with that cycle, the pre-increment value is captured.
- A down tick yielding 0 at edge t gives count_bcd=0 at t and state=DONE at t+1.
- ovf is asserted in the same cycle count_bcd shows all-0s after a wrap.

## Test plan
All scenarios use DIGITS=2, TICK_DIV=4.
- Reset: pulse rst_n low mid-count → all outputs 0, state=0 in the same cycle. After release, no ovf occurs.
- Up count: start_stop at cycle 0, run 40 cycles → count_bcd=8'h10, count_en=1. Then start_stop → PAUSE; count holds for 20 cycles. Then start_stop → counting resumes with no lost period.
- Lap: in COUNT at 8'h05, lap_rst → disp_bcd stays 8'h05 while count_bcd reaches 8'h08. lap_rst again → disp_bcd tracks count_bcd.
- Down/done: in IDLE, dir=1 with load of preset=8'h03, then start_stop → reaches 0 after 12 cycles, state=4 and done=1 on the next cycle. Any pulse then → IDLE.
- Wrap and priority: load preset=8'h99 in up mode, start → next tick gives count_bcd=8'h00 and a one-cycle ovf. start_stop and lap_rst together in COUNT → PAUSE.
- Clamp and guard: load preset=8'hAF → count_bcd=8'h99. In IDLE with dir=1 and count 0, start_stop → stays IDLE.
